// File: rtl/pe_ran_pkg.sv
// Shared constants, nucleotide encoding and matrix helpers for the
// pe_ran random nucleotide-substitution processing element.
package pe_ran_pkg;

    localparam int NUM_NUCL   = 16;
    localparam int NUCL_W     = 2;
    localparam int PROB_W     = 10;
    localparam int SUM_W      = 12;
    localparam int PROB_SCALE = 1000;
    localparam int LFSR_W     = 16;
    localparam int ROW_W      = 4 * PROB_W;
    localparam int MAT_W      = 4 * ROW_W;
    localparam int WORD_W     = NUM_NUCL * NUCL_W;

    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic [NUCL_W-1:0] {
        NUCL_A = 2'b00,
        NUCL_C = 2'b01,
        NUCL_G = 2'b10,
        NUCL_T = 2'b11
    } nucl_t;

    // P[row][col]: probability (x1000) that nucleotide row becomes col.
    function automatic logic [PROB_W-1:0] p_entry(input logic [MAT_W-1:0] mat,
                                                   input logic [NUCL_W-1:0] row,
                                                   input logic [NUCL_W-1:0] col);
        return mat[ROW_W*int'(row) + PROB_W*int'(col) +: PROB_W];
    endfunction

    function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] val, input int amt);
        logic [2*LFSR_W-1:0] dbl;
        dbl = {val, val} << (amt % LFSR_W);
        return dbl[2*LFSR_W-1 -: LFSR_W];
    endfunction

endpackage

// File: rtl/pe_ran_if.sv
// Data bundle between the sequence source, pe_ran and the alignment writer.
interface pe_ran_if;
    import pe_ran_pkg::*;

    logic [WORD_W-1:0] nucl_alig;
    logic [MAT_W-1:0]  matrix_P;
    logic [WORD_W-1:0] final_result;

    modport master (output nucl_alig, output matrix_P, input final_result);
    modport slave  (input nucl_alig, input matrix_P, output final_result);

endinterface

// File: rtl/pe_ran_lane.sv
// One nucleotide lane: private Galois LFSR, 0..999 draw and cumulative-row
// compare. The result is combinational; the top level registers it.
module pe_ran_lane
    import pe_ran_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_LANE = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUCL_W-1:0] nucl,
    input  logic [MAT_W-1:0]  matrix,
    output logic [NUCL_W-1:0] result
);

    logic [LFSR_W-1:0]  lfsr;
    logic [25:0]        prod;
    logic [PROB_W-1:0]  draw;
    logic [SUM_W-1:0]   cum_sum;
    logic               found;
    logic               unused_prod_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED_LANE;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ LFSR_MASK;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    // lfsr * 1000 as 512+256+128+64+32+8; the top 10 bits give 0..999.
    assign prod = {1'b0, lfsr, 9'b0} + {2'b0, lfsr, 8'b0} + {3'b0, lfsr, 7'b0}
                + {4'b0, lfsr, 6'b0} + {5'b0, lfsr, 5'b0} + {7'b0, lfsr, 3'b0};
    assign draw = prod[25:16];
    assign unused_prod_lo = ^prod[15:0];

    // First column whose running sum exceeds the draw wins; if the row never
    // gets there the nucleotide is kept unchanged.
    always_comb begin
        cum_sum = '0;
        found   = 1'b0;
        result  = nucl;
        for (int col = 0; col < 4; col++) begin
            cum_sum = cum_sum + SUM_W'(p_entry(matrix, nucl, NUCL_W'(col)));
            if (!found && ({2'b00, draw} < cum_sum)) begin
                result = NUCL_W'(col);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_ran.sv
// pe_ran top: sixteen independent sampling lanes feeding one output register.
module pe_ran
    import pe_ran_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic     clk,
    input  logic     reset,
    pe_ran_if.slave  bus
);

    logic [WORD_W-1:0] next_word;

    for (genvar i = 0; i < NUM_NUCL; i++) begin : g_lane
        pe_ran_lane #(
            .SEED_LANE (rotl(SEED, i))
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .nucl   (bus.nucl_alig[NUCL_W*i +: NUCL_W]),
            .matrix (bus.matrix_P),
            .result (next_word[NUCL_W*i +: NUCL_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.final_result <= '0;
        end else begin
            bus.final_result <= next_word;
        end
    end

endmodule

// File: tb/tb_pe_ran.sv
// Randomized self-checking bench for pe_ran against a behavioural model.
module tb_pe_ran;
    import pe_ran_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pe_ran_if bus();

    pe_ran dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] m_lfsr [16];
    logic [31:0] got_w;
    logic [31:0] rec [4000];
    int          cnt [16][4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_seed();
        for (int l = 0; l < 16; l++) begin
            logic [31:0] dbl;
            dbl = {16'hACE1, 16'hACE1} << l;
            m_lfsr[l] = dbl[31:16];
        end
    endfunction

    function automatic void model_advance();
        for (int l = 0; l < 16; l++)
            m_lfsr[l] = m_lfsr[l][0] ? ((m_lfsr[l] >> 1) ^ 16'hB400) : (m_lfsr[l] >> 1);
    endfunction

    // Draw r = floor(lfsr*1000/65536); pick first column with r < running sum.
    function automatic logic [31:0] model_word(input logic [31:0] nucl, input logic [159:0] mat);
        logic [31:0] w;
        w = '0;
        for (int l = 0; l < 16; l++) begin
            int n, r, s, pick;
            n    = int'(nucl[2*l +: 2]);
            r    = int'((longint'(m_lfsr[l]) * 1000) / 65536);
            s    = 0;
            pick = n;
            for (int c = 0; c < 4; c++) begin
                s += int'(mat[40*n + 10*c +: 10]);
                if (r < s) begin
                    pick = c;
                    break;
                end
            end
            w[2*l +: 2] = 2'(pick);
        end
        return w;
    endfunction

    function automatic logic [159:0] put(input logic [159:0] m, input int r, input int c, input int v);
        m[40*r + 10*c +: 10] = 10'(v);
        return m;
    endfunction

    task automatic cycle(input logic [31:0] nucl, input logic [159:0] mat);
        logic [31:0] exp;
        bus.nucl_alig = nucl;
        bus.matrix_P  = mat;
        exp = model_word(nucl, mat);
        @(posedge clk);
        model_advance();
        #1;
        got_w = bus.final_result;
        check_val("model", got_w, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_seed();
        #1;
        check_val("reset_out", bus.final_result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [159:0] ident, compl, unif, asym, rmat;
        logic         ok;

        ident = 160'hFA00000000003E80000000000FA00000000003E8;
        compl = '0;
        unif  = '0;
        for (int r = 0; r < 4; r++) begin
            compl = put(compl, r, 3 - r, 1000);
            for (int c = 0; c < 4; c++) unif = put(unif, r, c, 250);
        end
        asym = put(put(160'h0, 0, 0, 500), 0, 3, 500);

        bus.nucl_alig = 32'h51652D55;
        bus.matrix_P  = ident;
        model_seed();
        #3;
        check_val("reset_hold", bus.final_result, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            cycle(32'h51652D55, ident);
            check_val("identity", got_w, 32'h51652D55);
        end
        for (int k = 0; k < 20; k++) begin
            logic [31:0] v;
            v = $urandom;
            cycle(v, ident);
            check_val("identity_rand", got_w, v);
        end

        cycle(32'h00000000, compl);
        check_val("compl_zero", got_w, 32'hFFFFFFFF);
        cycle(32'h1B1B1B1B, compl);
        check_val("compl_1b", got_w, 32'hE4E4E4E4);
        cycle(32'hA5A5A5A5, 160'h0);
        check_val("zero_mat", got_w, 32'hA5A5A5A5);
        cycle(32'h3C3C3C3C, 160'h0);
        check_val("zero_mat2", got_w, 32'h3C3C3C3C);

        for (int k = 0; k < 300; k++) begin
            rmat = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    rmat = put(rmat, r, c, int'($urandom_range(0, 450)));
            cycle($urandom, rmat);
        end

        pulse_reset();
        for (int l = 0; l < 16; l++)
            for (int s = 0; s < 4; s++) cnt[l][s] = 0;
        for (int k = 0; k < 4000; k++) begin
            cycle(32'h0, unif);
            rec[k] = got_w;
            for (int l = 0; l < 16; l++) cnt[l][int'(got_w[2*l +: 2])]++;
        end
        for (int l = 0; l < 16; l++) begin
            ok = 1'b1;
            for (int s = 0; s < 4; s++)
                if (cnt[l][s] < 800 || cnt[l][s] > 1200) ok = 1'b0;
            check_val("uni_dist", 32'(ok), 32'h1);
        end

        for (int k = 0; k < 37; k++) cycle(32'h0, unif);
        pulse_reset();
        for (int k = 0; k < 4000; k++) begin
            cycle(32'h0, unif);
            check_val("replay", got_w, rec[k]);
        end

        for (int l = 0; l < 16; l++)
            for (int s = 0; s < 4; s++) cnt[l][s] = 0;
        for (int k = 0; k < 2000; k++) begin
            cycle(32'h0, asym);
            for (int l = 0; l < 16; l++) cnt[l][int'(got_w[2*l +: 2])]++;
        end
        for (int l = 0; l < 16; l++) begin
            ok = (cnt[l][1] == 0) && (cnt[l][2] == 0)
              && (cnt[l][0] >= 800) && (cnt[l][0] <= 1200)
              && (cnt[l][3] >= 800) && (cnt[l][3] <= 1200);
            check_val("asym_dist", 32'(ok), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
